// File: rtl/johnson_pkg.sv
// Shared Johnson digit code definitions, FSM state encoding and code helpers.
package johnson_pkg;

  localparam int unsigned JW = 5;

  typedef logic [JW-1:0] jcode_t;

  // Legal Johnson codes for digits 0..9
  localparam jcode_t J0 = 5'b00000;
  localparam jcode_t J1 = 5'b00001;
  localparam jcode_t J2 = 5'b00011;
  localparam jcode_t J3 = 5'b00111;
  localparam jcode_t J4 = 5'b01111;
  localparam jcode_t J5 = 5'b11111;
  localparam jcode_t J6 = 5'b11110;
  localparam jcode_t J7 = 5'b11100;
  localparam jcode_t J8 = 5'b11000;
  localparam jcode_t J9 = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // True when c is one of the ten digit codes
  function automatic logic is_legal_johnson(input jcode_t c);
    case (c)
      J0, J1, J2, J3, J4, J5, J6, J7, J8, J9: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // One twisted-ring shift in the requested direction
  function automatic jcode_t johnson_advance(input jcode_t c, input logic up);
    return up ? {c[3:0], ~c[4]} : {~c[0], c[4:1]};
  endfunction

  // True when advancing from c crosses the 9/0 boundary
  function automatic logic johnson_wraps(input jcode_t c, input logic up);
    return up ? (c == J9) : (c == J0);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..PRESCALE-1 counter with enable/clear and a terminal-count tick.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_c
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] TC = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // Tick is the terminal count while enabled; caller advances on this edge
  assign tick_c = en_i && (cnt_q == TC);

  // Next count: clear wins, then wrap at terminal count, else increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TC) ? '0 : cnt_q + PW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/johnson_digit_sequencer.sv
// Run/hold/clear sequencer producing a Johnson digit code with carry and illegal-code guard.
module johnson_digit_sequencer
  import johnson_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000000
) (
  input  logic         CLOCK_50,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         step,
  input  logic         up,
  output logic [JW-1:0] c,
  output logic         running,
  output logic         carry,
  output logic         err
);

  state_t state_q, state_d;
  jcode_t c_q, c_d;
  logic   running_q, running_d;
  logic   carry_q, carry_d;
  logic   err_q, err_d;
  logic   adv;
  logic   psc_clr;
  logic   tick;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (CLOCK_50),
    .rst_n  (rst_n),
    .en_i   (state_q == RUN),
    .clr_i  (psc_clr),
    .tick_c (tick)
  );

  assign c       = c_q;
  assign running = running_q;
  assign carry   = carry_q;
  assign err     = err_q;

  // Pulse priority clear > stop > start > step, then the advance itself
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    adv     = 1'b0;
    psc_clr = 1'b0;

    if (clear) begin
      state_d = IDLE;
      c_d     = J0;
      psc_clr = 1'b1;
    end else if (stop) begin
      // stop consumes the cycle in every state; only RUN actually moves
      if (state_q == RUN) begin
        state_d = HOLD;
      end
      psc_clr = 1'b1;
    end else if (start && (state_q != RUN)) begin
      state_d = RUN;
      psc_clr = 1'b1;
    end else if (state_q == RUN) begin
      adv = tick;
    end else if (step) begin
      adv = 1'b1;
    end

    if (adv) begin
      if (is_legal_johnson(c_q)) begin
        c_d     = johnson_advance(c_q, up);
        carry_d = johnson_wraps(c_q, up);
      end else begin
        c_d   = J0;
        err_d = 1'b1;
      end
    end

    running_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      c_q       <= J0;
      running_q <= 1'b0;
      carry_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      running_q <= running_d;
      carry_q   <= carry_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/johnson_digit_sequencer.md
Name: johnson_digit_sequencer

Overview:
- Controller that generates and sequences the 5-bit Johnson (twisted-ring) digit code consumed by the team's Johnson-to-7-segment decoder.
- Provides run/hold/clear control, up/down counting, a prescaled step rate, single-stepping and a decade carry for cascading digits.
- Sits between board pushbuttons/switches and the decoder's 5-bit code input.

Parameters:
- PRESCALE, 50000000, clock cycles per count step while running (1 s at 50 MHz); must be >= 2.
- PW, $clog2(PRESCALE), prescaler counter width (derived localparam, not overridable).

Ports:
- CLOCK_50  input  1  system clock; all state is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: enter RUN.
- stop  input  1  one-cycle pulse: enter HOLD.
- clear  input  1  one-cycle pulse: code to 00000, enter IDLE.
- step  input  1  one-cycle pulse: advance one count, honoured in IDLE/HOLD only.
- up  input  1  direction: 1 = 0→9, 0 = 9→0; sampled at each advance.
- c  output  5  Johnson digit code to decoder (registered).
- running  output  1  high in RUN.
- carry  output  1  one-cycle pulse on wrap: 10000→00000 when up, 00000→10000 when down.
- err  output  1  one-cycle pulse when an illegal code is detected and forced to 00000.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, c=00000, prescaler=0, running=0, carry=0, err=0.
- Legal codes, digit 0..9: 00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000.
- Advance up: c <= {c[3:0], ~c[4]}. Advance down: c <= {~c[0], c[4:1]}.
- States:
  - IDLE: entered on reset/clear.
  - RUN: advance on every prescaler terminal count.
  - HOLD: frozen.
- Transitions:
  - IDLE -start-> RUN.
  - RUN -stop-> HOLD.
  - HOLD -start-> RUN.
  - any -clear-> IDLE.
- Priority when pulses coincide in one cycle: clear > stop > start > step.
  - clear+start together → IDLE, c=00000.
  - stop+start in RUN → HOLD.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN. Terminal count = PRESCALE-1; the counter returns to 0 on the same edge the advance occurs.
  - Cleared to 0 on entering RUN, so the first advance happens exactly PRESCALE cycles after the start pulse is sampled.
  - Cleared on stop and on clear.
- Step: in IDLE or HOLD, step advances c by one on the next edge with no prescaler involvement and no state change. Step is ignored in RUN.
- Latency: c, carry and err update on the same edge as the triggering tick/step. No combinational input→output paths.
- carry:
  - Asserted for exactly the cycle after the wrap edge; applies to both RUN and step advances.
  - Not asserted on clear.
- Illegal-code guard: at any advance, if c is not one of the 10 legal codes, c <= 00000 and err pulses for one cycle instead of advancing; carry is not asserted.
- Reset mid-run: immediate return to reset values; no carry/err emitted.
- up changes between advances are legal and take effect at the next advance. Reversal never produces carry unless the wrap edge itself is crossed.

Decomposition:
- Shared package johnson_pkg holds:
  - the 10 legal-code constants (J0..J9);
  - the state enum (IDLE, RUN, HOLD);
  - a function is_legal_johnson(c), reused by the decoder bench.
- One natural sub-module, tick_prescaler: counter with enable/clear and a one-cycle terminal-count tick, parameterised by PRESCALE.

Test Plan:
1. PRESCALE=4; reset, start at cycle 0 with up=1 → c advances 00000→00001 at cycle 4, then 00011 at cycle 8; running=1 throughout.
2. Run up from 10000 (digit 9) → next tick c=00000 and carry high for exactly one cycle. Repeat with up=0 from 00000 → c=10000, carry pulses once.
3. In HOLD at 00111, step pulse with up=0 → c=00011 next edge, state stays HOLD, no prescaler activity. Step pulse during RUN → no extra advance.
4. Same cycle start+clear from HOLD at 11100 → c=00000, state IDLE, running=0. Same cycle stop+start in RUN → HOLD.
5. Force c=01010 via bench backdoor, then issue step → c=00000, err one-cycle pulse, carry=0.
6. Assert rst_n=0 asynchronously mid-prescale in RUN at 11111 → c=00000, running=0 before the next clock edge. Release, then start → first advance 4 cycles later.
